// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing control slice.
package pipeline_pkg;

    // Interrupt entry sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        TAKE = 2'd2,
        SVC  = 2'd3
    } irq_state_t;

    // Register r0 is hard-wired to zero, so it can never carry a load-use dependency.
    localparam logic [4:0]  REG_ZERO        = 5'd0;

    // Default interrupt vector address.
    localparam logic [31:0] DEFAULT_IRQ_VEC = 32'h8000_0004;

    // Width of the mul/div busy counter (latencies 1..15).
    localparam int          MD_CNT_W        = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// All signals are level-valued and sampled every cycle; there is no valid/ready
// handshake: the datapath presents ID/EX decode info each cycle and obeys the
// stall/flush controls at the very next clock edge.
interface pipeline_hazard_ctrl_if;
    import pipeline_pkg::*;

    // Datapath -> controller
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_is_md;
    logic        id_reads_hilo;
    logic        id_jump;
    logic        id_eret;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;
    logic [31:0] ifid_pc;
    logic        irq_in;

    // Controller -> datapath
    logic        pc_stall;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        idex_flush;
    logic        irq_take;
    logic [31:0] irq_vector;
    logic [31:0] epc;
    logic        md_busy;
    logic        in_service;
    irq_state_t  dbg_state;

    // Datapath side
    modport master (
        output id_rs, id_rt, id_uses_rt, id_is_md, id_reads_hilo, id_jump, id_eret,
        output ex_memread, ex_rd, ex_branch_taken, ifid_pc, irq_in,
        input  pc_stall, ifid_stall, ifid_flush, idex_flush, irq_take, irq_vector,
        input  epc, md_busy, in_service, dbg_state
    );

    // Controller side
    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_is_md, id_reads_hilo, id_jump, id_eret,
        input  ex_memread, ex_rd, ex_branch_taken, ifid_pc, irq_in,
        output pc_stall, ifid_stall, ifid_flush, idex_flush, irq_take, irq_vector,
        output epc, md_busy, in_service, dbg_state
    );

endinterface

// File: rtl/md_busy_counter.sv
// Mul/div busy tracker: loads the unit latency on issue, then counts down to zero.
module md_busy_counter
    import pipeline_pkg::*;
#(
    parameter int MD_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    output logic o_busy
);

    logic [MD_CNT_W-1:0] r_cnt;

    // Load on accepted issue, otherwise decrement toward zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= MD_CNT_W'(MD_LAT);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard and sequencing controller: load-use and mul/div stalls,
// branch/jump flushes, and interrupt entry with EPC capture.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int          MD_LAT  = 4,
    parameter logic [31:0] IRQ_VEC = DEFAULT_IRQ_VEC
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  bus
);

    irq_state_t  r_state;
    logic [31:0] r_epc;
    logic        r_in_service;

    logic w_lu_hz;
    logic w_md_hz;
    logic w_stall;
    logic w_take;
    logic w_take_ok;
    logic w_md_load;
    logic w_md_busy;

    // Hazard detection from the ID/EX instruction pair and mul/div occupancy.
    always_comb begin
        w_lu_hz = bus.ex_memread && (bus.ex_rd != REG_ZERO) &&
                  ((bus.ex_rd == bus.id_rs) ||
                   (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));
        w_md_hz = w_md_busy && (bus.id_is_md || bus.id_reads_hilo);
        // A taken branch means the ID instruction is on the wrong path anyway.
        w_stall = (w_lu_hz || w_md_hz) && !bus.ex_branch_taken;
        w_take  = (r_state == TAKE);
        // The ID instruction is a safe restart point only when nothing else redirects or holds it.
        w_take_ok = !w_stall && !bus.ex_branch_taken && !bus.id_jump && !w_md_busy;
    end

    // Pipeline control outputs; interrupt entry overrides any hazard.
    always_comb begin
        bus.pc_stall   = w_stall && !w_take;
        bus.ifid_stall = w_stall && !w_take;
        bus.ifid_flush = w_take || bus.ex_branch_taken ||
                         (bus.id_jump && !w_stall);
        bus.idex_flush = w_take || bus.ex_branch_taken || w_stall;
        bus.irq_take   = w_take;
    end

    // A mul/div issues only if its ID instruction actually advances into EX.
    assign w_md_load = bus.id_is_md && !bus.idex_flush;

    md_busy_counter #(
        .MD_LAT (MD_LAT)
    ) u_md_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_md_load),
        .o_busy (w_md_busy)
    );

    // Interrupt entry sequencer; the request is latched once PEND is reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_epc        <= '0;
            r_in_service <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.irq_in && !r_in_service) begin
                        r_state <= PEND;
                    end
                end
                PEND: begin
                    if (w_take_ok) begin
                        r_state <= TAKE;
                    end
                end
                TAKE: begin
                    // The discarded ID instruction resumes from here after eret.
                    r_epc        <= bus.ifid_pc;
                    r_state      <= SVC;
                    r_in_service <= 1'b1;
                end
                SVC: begin
                    if (bus.id_eret && !w_stall) begin
                        r_state      <= IDLE;
                        r_in_service <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.irq_vector = IRQ_VEC;
    assign bus.epc        = r_epc;
    assign bus.md_busy    = w_md_busy;
    assign bus.in_service = r_in_service;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for the hazard
// equations plus hand-written multi-cycle mul/div and interrupt sequences.
module tb_pipeline_hazard_ctrl;
    import pipeline_pkg::*;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    pipeline_hazard_ctrl_if bus();

    pipeline_hazard_ctrl #(
        .MD_LAT  (4),
        .IRQ_VEC (32'h8000_0004)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       hilo;
        logic       jump;
        logic       memread;
        logic [4:0] rd;
        logic       bt;
        logic [3:0] exp_ctl;   // {pc_stall, ifid_stall, ifid_flush, idex_flush}
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.id_rs           = '0;
        bus.id_rt           = '0;
        bus.id_uses_rt      = 1'b0;
        bus.id_is_md        = 1'b0;
        bus.id_reads_hilo   = 1'b0;
        bus.id_jump         = 1'b0;
        bus.id_eret         = 1'b0;
        bus.ex_memread      = 1'b0;
        bus.ex_rd           = '0;
        bus.ex_branch_taken = 1'b0;
        bus.ifid_pc         = '0;
        bus.irq_in          = 1'b0;
    endtask

    // Advance to just after the next active edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ctl_bits();
        return {bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_flush};
    endfunction

    initial begin
        int stalls;
        n_pass  = 0;
        n_total = 0;

        //                rs     rt     urt  hilo jump mrd  rd     bt   exp
        vecs[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 4'b0000};
        vecs[1]  = '{5'd8,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  1'b0, 4'b1101};
        vecs[2]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 4'b0000};
        vecs[3]  = '{5'd1,  5'd9,  1'b1, 1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 4'b1101};
        vecs[4]  = '{5'd1,  5'd9,  1'b0, 1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 4'b0000};
        vecs[5]  = '{5'd8,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd8,  1'b0, 4'b0000};
        vecs[6]  = '{5'd8,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  1'b1, 4'b0011};
        vecs[7]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 4'b0011};
        vecs[8]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 4'b0010};
        vecs[9]  = '{5'd8,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 4'b1101};
        vecs[10] = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b1, 4'b0011};
        vecs[11] = '{5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 4'b0000};

        // Reset
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_ctl",       32'(ctl_bits()),     32'h0);
        check("reset_irq_take",  32'(bus.irq_take),   32'h0);
        check("reset_irq_vec",   bus.irq_vector,      32'h8000_0004);
        check("reset_epc",       bus.epc,             32'h0);
        check("reset_busy_svc",  32'({bus.md_busy, bus.in_service}), 32'h0);
        check("reset_state",     32'(bus.dbg_state),  32'(IDLE));

        // Combinational hazard table (FSM idle, mul/div idle)
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            clear_inputs();
            bus.id_rs           = vecs[i].rs;
            bus.id_rt           = vecs[i].rt;
            bus.id_uses_rt      = vecs[i].uses_rt;
            bus.id_reads_hilo   = vecs[i].hilo;
            bus.id_jump         = vecs[i].jump;
            bus.ex_memread      = vecs[i].memread;
            bus.ex_rd           = vecs[i].rd;
            bus.ex_branch_taken = vecs[i].bt;
            @(negedge clk);
            check($sformatf("vec%0d_ctl", i), 32'(ctl_bits()), 32'(vecs[i].exp_ctl));
        end

        // Mul/div: issue, then mfhi held until the unit is free
        next_cycle();
        clear_inputs();
        bus.id_is_md = 1'b1;
        @(negedge clk);
        check("md_issue_ctl", 32'(ctl_bits()), 32'h0);
        next_cycle();
        bus.id_is_md      = 1'b0;
        bus.id_reads_hilo = 1'b1;
        @(negedge clk);
        check("md_busy_after_issue", 32'(bus.md_busy), 32'h1);
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.pc_stall) break;
            stalls++;
            next_cycle();
            @(negedge clk);
        end
        check("md_stall_cycles", 32'(stalls), 32'd4);
        check("md_release_busy", 32'(bus.md_busy), 32'h0);
        check("md_release_ctl",  32'(ctl_bits()), 32'h0);

        // Clean interrupt entry, with a load-use hazard overlapping TAKE
        next_cycle();
        clear_inputs();
        bus.ifid_pc = 32'h40;
        bus.irq_in  = 1'b1;
        @(negedge clk);
        check("irq_c0_state", 32'(bus.dbg_state), 32'(IDLE));
        check("irq_c0_take",  32'(bus.irq_take),  32'h0);
        next_cycle();
        @(negedge clk);
        check("irq_c1_state", 32'(bus.dbg_state), 32'(PEND));
        check("irq_c1_take",  32'(bus.irq_take),  32'h0);
        next_cycle();
        bus.ex_memread = 1'b1;
        bus.ex_rd      = 5'd8;
        bus.id_rs      = 5'd8;
        @(negedge clk);
        check("irq_c2_take",  32'(bus.irq_take), 32'h1);
        check("irq_c2_ctl",   32'(ctl_bits()),   32'b0011);
        next_cycle();
        bus.ex_memread = 1'b0;
        bus.ex_rd      = 5'd0;
        bus.id_rs      = 5'd0;
        @(negedge clk);
        check("irq_c3_epc",   bus.epc,                 32'h40);
        check("irq_c3_svc",   32'(bus.in_service),     32'h1);
        check("irq_c3_state", 32'(bus.dbg_state),      32'(SVC));
        check("irq_c3_take",  32'(bus.irq_take),       32'h0);
        next_cycle();
        bus.irq_in  = 1'b0;
        bus.id_eret = 1'b1;
        @(negedge clk);
        check("irq_c4_state_ignores_irq", 32'(bus.dbg_state), 32'(SVC));
        next_cycle();
        bus.id_eret = 1'b0;
        @(negedge clk);
        check("irq_eret_state", 32'(bus.dbg_state),  32'(IDLE));
        check("irq_eret_svc",   32'(bus.in_service), 32'h0);
        check("irq_eret_epc",   bus.epc,             32'h40);

        // Interrupt blocked by a busy mul/div; request drops while pending
        next_cycle();
        clear_inputs();
        bus.ifid_pc  = 32'h80;
        bus.id_is_md = 1'b1;
        next_cycle();
        bus.id_is_md = 1'b0;
        next_cycle();
        bus.irq_in = 1'b1;
        @(negedge clk);
        check("blk_b2_busy",  32'(bus.md_busy),   32'h1);
        check("blk_b2_state", 32'(bus.dbg_state), 32'(IDLE));
        next_cycle();
        bus.irq_in = 1'b0;
        @(negedge clk);
        check("blk_b3_state", 32'(bus.dbg_state), 32'(PEND));
        next_cycle();
        @(negedge clk);
        check("blk_b4_state", 32'(bus.dbg_state), 32'(PEND));
        next_cycle();
        @(negedge clk);
        check("blk_b5_busy",  32'(bus.md_busy),   32'h0);
        check("blk_b5_state", 32'(bus.dbg_state), 32'(PEND));
        check("blk_b5_take",  32'(bus.irq_take),  32'h0);
        next_cycle();
        @(negedge clk);
        check("blk_b6_take",  32'(bus.irq_take),  32'h1);

        // Reset asserted during TAKE wins at the next edge
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        check("rst_take_state", 32'(bus.dbg_state),  32'(IDLE));
        check("rst_take_epc",   bus.epc,             32'h0);
        check("rst_take_svc",   32'(bus.in_service), 32'h0);
        check("rst_take_ctl",   32'({ctl_bits(), bus.irq_take}), 32'h0);
        next_cycle();
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
